// File: rtl/can_rx_priority_logic.sv
// can_rx_priority_logic: classifies received CAN frames into the RX HPB or RX FIFO, counting drops.
// Define CAN_RX_HPB_FALLBACK_EN to redirect matching frames to the FIFO when the HPB is full.
module can_rx_priority_logic #(
    parameter int DATA_W     = 128,
    parameter int ID_W       = 11,
    parameter int ID_LSB     = 117,
    parameter int DROP_CNT_W = 8
) (
    input  logic                  i_sys_clk,
    input  logic                  i_reset,
    input  logic [DATA_W-1:0]     i_recv_data,
    input  logic                  i_recv_valid,
    output logic                  o_recv_ack,
    input  logic                  i_filter_en,
    input  logic [ID_W-1:0]       i_filter_id,
    input  logic [ID_W-1:0]       i_filter_mask,
    input  logic                  i_hpb_full,
    output logic [DATA_W-1:0]     o_hpb_data,
    output logic                  o_hpb_w_en,
    input  logic                  i_rx_full,
    output logic [DATA_W-1:0]     o_fifo_data,
    output logic                  o_fifo_w_en,
    output logic [DROP_CNT_W-1:0] o_drop_cnt,
    output logic                  o_busy
);
    typedef enum logic [1:0] {IDLE, CLASSIFY, WRITE, ACK} state_t;
    state_t state;
    logic [DATA_W-1:0] frame;
    logic [ID_W-1:0] id;
    logic match, to_hpb, to_fifo;
    assign id     = frame[ID_LSB +: ID_W];
    assign match  = i_filter_en & (((id ^ i_filter_id) & i_filter_mask) == '0);
    assign to_hpb = match & ~i_hpb_full;
`ifdef CAN_RX_HPB_FALLBACK_EN
    assign to_fifo = ~to_hpb & ~i_rx_full;
`else
    assign to_fifo = ~match & ~i_rx_full;
`endif
    assign o_busy = (state != IDLE);
    always_ff @(posedge i_sys_clk or posedge i_reset) begin
        if (i_reset) begin
            state       <= IDLE;
            frame       <= '0;
            o_recv_ack  <= 1'b0;
            o_hpb_data  <= '0;
            o_hpb_w_en  <= 1'b0;
            o_fifo_data <= '0;
            o_fifo_w_en <= 1'b0;
            o_drop_cnt  <= '0;
        end else begin
            case (state)
                IDLE: if (i_recv_valid) begin
                    frame <= i_recv_data;
                    state <= CLASSIFY;
                end
                CLASSIFY: begin
                    if (to_hpb) begin
                        o_hpb_data <= frame;
                        o_hpb_w_en <= 1'b1;
                    end else if (to_fifo) begin
                        o_fifo_data <= frame;
                        o_fifo_w_en <= 1'b1;
                    end else if (o_drop_cnt != '1) begin
                        o_drop_cnt <= o_drop_cnt + 1'b1;
                    end
                    state <= WRITE;
                end
                WRITE: begin
                    o_hpb_w_en  <= 1'b0;
                    o_fifo_w_en <= 1'b0;
                    o_recv_ack  <= 1'b1;
                    state       <= ACK;
                end
                default: if (!i_recv_valid) begin
                    o_recv_ack <= 1'b0;
                    state      <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_can_rx_priority_logic.sv
// tb_can_rx_priority_logic: randomized and directed checks of can_rx_priority_logic against a frame-level routing model.
module tb_can_rx_priority_logic;
    logic         sys_clk = 1'b0;
    logic         reset = 1'b1;
    logic [127:0] recv_data = '0;
    logic         recv_valid = 1'b0;
    logic         recv_ack;
    logic         filter_en = 1'b0;
    logic [10:0]  filter_id = '0;
    logic [10:0]  filter_mask = '0;
    logic         hpb_full = 1'b0;
    logic [127:0] hpb_data;
    logic         hpb_w_en;
    logic         rx_full = 1'b0;
    logic [127:0] fifo_data;
    logic         fifo_w_en;
    logic [7:0]   drop_cnt;
    logic         busy;

    int checks = 0;
    int errors = 0;
    logic [127:0] exp_hpb = '0;
    logic [127:0] exp_fifo = '0;
    int exp_drop = 0;
    logic [127:0] d;

    can_rx_priority_logic dut (
        .i_sys_clk(sys_clk), .i_reset(reset),
        .i_recv_data(recv_data), .i_recv_valid(recv_valid), .o_recv_ack(recv_ack),
        .i_filter_en(filter_en), .i_filter_id(filter_id), .i_filter_mask(filter_mask),
        .i_hpb_full(hpb_full), .o_hpb_data(hpb_data), .o_hpb_w_en(hpb_w_en),
        .i_rx_full(rx_full), .o_fifo_data(fifo_data), .o_fifo_w_en(fifo_w_en),
        .o_drop_cnt(drop_cnt), .o_busy(busy)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // 0 = dropped, 1 = HPB, 2 = FIFO
    function automatic int route(input logic [127:0] f, input bit fen, input logic [10:0] fid,
                                 input logic [10:0] fm, input bit hf, input bit rf);
        logic [10:0] fr_id;
        bit m, fallback;
        fr_id = f[127:117];
        m = fen && ((fr_id & fm) == (fid & fm));
`ifdef CAN_RX_HPB_FALLBACK_EN
        fallback = 1;
`else
        fallback = 0;
`endif
        if (m && !hf) return 1;
        if (!m && !rf) return 2;
        if (m && fallback && !rf) return 2;
        return 0;
    endfunction

    function automatic logic [127:0] mk(input logic [10:0] fid);
        logic [127:0] f;
        f = {$urandom, $urandom, $urandom, $urandom};
        f[127:117] = fid;
        return f;
    endfunction

    // Caller is at a negedge; drives the frame and watches seven cycles.
    task automatic run_frame(input logic [127:0] f, input bit fen, input logic [10:0] fid,
                             input logic [10:0] fm, input bit hf, input bit rf, input bit early);
        int r, nh, nf, sc, af, ac;
        r = route(f, fen, fid, fm, hf, rf);
        recv_data = f; recv_valid = 1'b1;
        filter_en = fen; filter_id = fid; filter_mask = fm;
        hpb_full = hf; rx_full = rf;
        nh = 0; nf = 0; sc = 0; af = 0; ac = 0;
        for (int c = 1; c <= 7; c++) begin
            @(negedge sys_clk);
            if (hpb_w_en) begin nh++; sc = c; end
            if (fifo_w_en) begin nf++; sc = c; end
            if (recv_ack) begin ac++; if (af == 0) af = c; recv_valid = 1'b0; end
            if (early && c == 1) recv_valid = 1'b0;
            if (c == 2) begin
                filter_en = ~fen; filter_id = $urandom; filter_mask = $urandom;
                hpb_full = ~hf; rx_full = ~rf;
            end
        end
        if (r == 1) exp_hpb = f;
        if (r == 2) exp_fifo = f;
        if (r == 0) exp_drop = (exp_drop >= 255) ? 255 : exp_drop + 1;
        chk("hpb_pulses", nh, (r == 1) ? 1 : 0);
        chk("fifo_pulses", nf, (r == 2) ? 1 : 0);
        if (r != 0) chk("strobe_cycle", sc, 2);
        chk("ack_first_cycle", af, 3);
        chk("ack_cycles", ac, 1);
        chk("hpb_data", hpb_data, exp_hpb);
        chk("fifo_data", fifo_data, exp_fifo);
        chk("drop_cnt", drop_cnt, exp_drop);
        chk("busy_idle", busy, 0);
    endtask

    task automatic chk_reset_outputs();
        chk("rst_ack", recv_ack, 0);
        chk("rst_hpb_w_en", hpb_w_en, 0);
        chk("rst_fifo_w_en", fifo_w_en, 0);
        chk("rst_hpb_data", hpb_data, 0);
        chk("rst_fifo_data", fifo_data, 0);
        chk("rst_drop_cnt", drop_cnt, 0);
        chk("rst_busy", busy, 0);
    endtask

    initial begin
        logic [10:0] fid, fm, rid;
        repeat (2) @(negedge sys_clk);
        chk_reset_outputs();
        reset = 1'b0;
        @(negedge sys_clk);
        run_frame(mk(11'h123), 1, 11'h123, 11'h7FF, 0, 0, 0);
        run_frame(mk(11'h124), 1, 11'h123, 11'h7FF, 0, 0, 0);
        run_frame(mk(11'h1FF), 1, 11'h100, 11'h700, 0, 0, 0);
        run_frame(mk(11'h200), 1, 11'h100, 11'h700, 0, 0, 0);
        run_frame(mk(11'h123), 1, 11'h123, 11'h7FF, 1, 0, 0);
        run_frame(mk(11'h123), 1, 11'h123, 11'h7FF, 1, 1, 0);
        run_frame(mk(11'h123), 0, 11'h123, 11'h7FF, 0, 0, 0);
        run_frame(mk(11'h5A5), 1, 11'h123, 11'h000, 0, 0, 0);
        run_frame(mk(11'h124), 1, 11'h123, 11'h7FF, 0, 0, 1);
        for (int i = 0; i < 200; i++) begin
            fid = $urandom;
            case ($urandom_range(0, 3))
                0: fm = 11'h7FF;
                1: fm = 11'h000;
                default: fm = $urandom;
            endcase
            rid = $urandom;
            if ($urandom_range(0, 1) == 0) rid = fid ^ (rid & ~fm);
            run_frame(mk(rid), $urandom_range(0, 3) != 0, fid, fm,
                      $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
                      $urandom_range(0, 7) == 0);
        end
        for (int i = 0; i < 260; i++) begin
            rid = $urandom;
            if (rid == 11'h123) rid = 11'h124;
            run_frame(mk(rid), 1, 11'h123, 11'h7FF, $urandom_range(0, 1), 1, 0);
        end
        chk("drop_saturated", drop_cnt, 255);
        d = mk(11'h123);
        recv_data = d; recv_valid = 1'b1;
        filter_en = 1'b1; filter_id = 11'h123; filter_mask = 11'h7FF;
        hpb_full = 1'b0; rx_full = 1'b0;
        repeat (3) @(negedge sys_clk);
        chk("pre_reset_ack", recv_ack, 1);
        #2 reset = 1'b1;
        #1 chk_reset_outputs();
        exp_hpb = '0; exp_fifo = '0; exp_drop = 0;
        @(negedge sys_clk);
        reset = 1'b0;
        run_frame(d, 1, 11'h123, 11'h7FF, 0, 0, 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end
endmodule
